// File: rtl/act_weight_fetch_ctrlr.sv
// Streams activation and weight bytes from their SRAMs to the row-memory distributors,
// one or three passes per run, with the per-pass index riding alongside each byte.
module act_weight_fetch_ctrlr #(
  parameter int INPUT_BW         = 8,
  parameter int ACT_PER_CORE     = 11,
  parameter int WEIGHT_PER_CORE  = 9,
  parameter int ACT_SRAM_ADDR    = 13,
  parameter int WEIGHT_SRAM_ADDR = 11
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              done,
  output logic                              cfg_err,
  input  logic [5:0]                        OC,
  input  logic [5:0]                        IMG_H,
  input  logic [5:0]                        IMG_W,
  input  logic [2:0]                        K,
  output logic                              act_sram_en,
  output logic [ACT_SRAM_ADDR-1:0]          act_sram_addr,
  input  logic signed [INPUT_BW-1:0]        act_sram_rdata,
  output logic                              weight_sram_en,
  output logic [WEIGHT_SRAM_ADDR-1:0]       weight_sram_addr,
  input  logic signed [INPUT_BW-1:0]        weight_sram_rdata,
  output logic signed [INPUT_BW-1:0]        act_row_mem_data,
  output logic [ACT_PER_CORE-1:0]           act_row_mem_addr,
  output logic signed [INPUT_BW-1:0]        weight_row_mem_data,
  output logic [WEIGHT_PER_CORE-1:0]        weight_row_mem_addr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t state_r, state_nxt_s;

  logic [6:0]  hin_s, win_s;
  logic [13:0] act_n_calc_s;
  logic [11:0] wgt_n_calc_s;
  logic        legal_calc_s;

  logic [13:0] act_n_r;
  logic [11:0] wgt_n_r;
  logic        legal_r;
  logic [1:0]  last_pass_r;
  logic [1:0]  pass_r;
  logic        drain_cnt_r;
  logic        all_issued_r;

  logic [ACT_SRAM_ADDR-1:0]    act_base_r;
  logic [WEIGHT_SRAM_ADDR-1:0] wgt_base_r;
  logic [ACT_PER_CORE-1:0]     act_idx_r;
  logic [WEIGHT_PER_CORE-1:0]  wgt_idx_r;

  logic                        s1_act_vld_r, s1_wgt_vld_r;
  logic [ACT_PER_CORE-1:0]     s1_act_idx_r;
  logic [WEIGHT_PER_CORE-1:0]  s1_wgt_idx_r;

  logic accept_s, go_s, cfg_err_s, done_s, fetch_s;
  logic a_last_s, w_last_s, pass_end_s, more_pass_s;

  // Geometry from the live config inputs; sized so no product can truncate.
  always_comb begin
    hin_s        = 7'(IMG_H) + 7'(K) - 7'd1;
    win_s        = 7'(IMG_W) + 7'(K) - 7'd1;
    act_n_calc_s = 14'(hin_s) * 14'(win_s);
    wgt_n_calc_s = 12'(K) * 12'(K) * 12'(OC);
    legal_calc_s = ((K == 3'd1) || (K == 3'd3) || (K == 3'd5)) &&
                   (OC != 6'd0) && (IMG_H != 6'd0) && (IMG_W != 6'd0) &&
                   (act_n_calc_s <= 14'd2047) && (wgt_n_calc_s <= 12'd511);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state; FETCH only ends once the last bytes have left the SRAM stage.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? CHECK : IDLE;
      CHECK:   state_nxt_s = legal_r ? FETCH : IDLE;
      FETCH:   state_nxt_s = (all_issued_r && !s1_act_vld_r && !s1_wgt_vld_r) ? DRAIN : FETCH;
      DRAIN:   state_nxt_s = drain_cnt_r ? HOLD : DRAIN;
      HOLD:    state_nxt_s = start ? CHECK : HOLD;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    accept_s  = 1'b0;
    go_s      = 1'b0;
    cfg_err_s = 1'b0;
    done_s    = 1'b0;
    fetch_s   = 1'b0;
    case (state_r)
      IDLE:    accept_s = start;
      CHECK:   begin
        go_s      = legal_r;
        cfg_err_s = !legal_r;
      end
      FETCH:   fetch_s = 1'b1;
      DRAIN:   done_s = drain_cnt_r;
      HOLD:    accept_s = start;
      default: accept_s = 1'b0;
    endcase
  end

  // Per-stream end-of-pass detection.
  always_comb begin
    a_last_s    = act_sram_en && (act_idx_r == ACT_PER_CORE'(act_n_r - 14'd1));
    w_last_s    = weight_sram_en && (wgt_idx_r == WEIGHT_PER_CORE'(wgt_n_r - 12'd1));
    pass_end_s  = (a_last_s || !act_sram_en) && (w_last_s || !weight_sram_en);
    more_pass_s = (pass_r != last_pass_r);
  end

  // Config latch and pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_n_r     <= 14'd0;
      wgt_n_r     <= 12'd0;
      legal_r     <= 1'b0;
      last_pass_r <= 2'd0;
      drain_cnt_r <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (accept_s) begin
        act_n_r     <= act_n_calc_s;
        wgt_n_r     <= wgt_n_calc_s;
        legal_r     <= legal_calc_s;
        last_pass_r <= (K == 3'd3) ? 2'd0 : 2'd2;
      end
      drain_cnt_r <= (state_r == DRAIN) ? !drain_cnt_r : 1'b0;
      done        <= done_s;
      cfg_err     <= cfg_err_s;
    end
  end

  // Issue stage: a finished stream parks its index at the count until the pass ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_sram_en      <= 1'b0;
      weight_sram_en   <= 1'b0;
      act_sram_addr    <= '0;
      weight_sram_addr <= '0;
      act_base_r       <= '0;
      wgt_base_r       <= '0;
      act_idx_r        <= '0;
      wgt_idx_r        <= '0;
      pass_r           <= 2'd0;
      all_issued_r     <= 1'b0;
    end else if (go_s) begin
      act_sram_en      <= 1'b1;
      weight_sram_en   <= 1'b1;
      act_sram_addr    <= '0;
      weight_sram_addr <= '0;
      act_base_r       <= '0;
      wgt_base_r       <= '0;
      act_idx_r        <= '0;
      wgt_idx_r        <= '0;
      pass_r           <= 2'd0;
      all_issued_r     <= 1'b0;
    end else if (fetch_s && pass_end_s && more_pass_s) begin
      pass_r           <= pass_r + 2'd1;
      act_base_r       <= act_base_r + ACT_SRAM_ADDR'(act_n_r);
      wgt_base_r       <= wgt_base_r + WEIGHT_SRAM_ADDR'(wgt_n_r);
      act_sram_addr    <= act_base_r + ACT_SRAM_ADDR'(act_n_r);
      weight_sram_addr <= wgt_base_r + WEIGHT_SRAM_ADDR'(wgt_n_r);
      act_sram_en      <= 1'b1;
      weight_sram_en   <= 1'b1;
      act_idx_r        <= '0;
      wgt_idx_r        <= '0;
    end else if (fetch_s) begin
      if (act_sram_en) begin
        act_idx_r   <= act_idx_r + ACT_PER_CORE'(1'b1);
        act_sram_en <= !a_last_s;
        if (!a_last_s) act_sram_addr <= act_sram_addr + ACT_SRAM_ADDR'(1'b1);
      end
      if (weight_sram_en) begin
        wgt_idx_r      <= wgt_idx_r + WEIGHT_PER_CORE'(1'b1);
        weight_sram_en <= !w_last_s;
        if (!w_last_s) weight_sram_addr <= weight_sram_addr + WEIGHT_SRAM_ADDR'(1'b1);
      end
      if (pass_end_s) all_issued_r <= 1'b1;
    end else if (accept_s) begin
      act_idx_r <= '0;
      wgt_idx_r <= '0;
    end
  end

  // SRAM-latency stage carries valid and index beside the read data.
  always_ff @(posedge clk) begin
    if (reset || accept_s) begin
      s1_act_vld_r <= 1'b0;
      s1_wgt_vld_r <= 1'b0;
      s1_act_idx_r <= '0;
      s1_wgt_idx_r <= '0;
    end else begin
      s1_act_vld_r <= act_sram_en;
      s1_wgt_vld_r <= weight_sram_en;
      s1_act_idx_r <= act_idx_r;
      s1_wgt_idx_r <= wgt_idx_r;
    end
  end

  // Output register; data only moves on a valid read, addresses clear on a new start.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_row_mem_data    <= '0;
      weight_row_mem_data <= '0;
      act_row_mem_addr    <= '0;
      weight_row_mem_addr <= '0;
    end else if (accept_s) begin
      act_row_mem_addr    <= '0;
      weight_row_mem_addr <= '0;
    end else begin
      act_row_mem_addr    <= s1_act_idx_r;
      weight_row_mem_addr <= s1_wgt_idx_r;
      if (s1_act_vld_r) act_row_mem_data <= act_sram_rdata;
      if (s1_wgt_vld_r) weight_row_mem_data <= weight_sram_rdata;
    end
  end

endmodule

// File: tb/tb_act_weight_fetch_ctrlr.sv
// Randomized bench for act_weight_fetch_ctrlr: a cycle-indexed model of the
// issue/output schedule derived from pass length and counts, plus SRAM arrays.
module tb_act_weight_fetch_ctrlr;

  logic              clk = 1'b0;
  logic              reset, start;
  logic              done, cfg_err;
  logic [5:0]        OC, IMG_H, IMG_W;
  logic [2:0]        K;
  logic              act_sram_en, weight_sram_en;
  logic [12:0]       act_sram_addr;
  logic [10:0]       weight_sram_addr;
  logic signed [7:0] act_sram_rdata, weight_sram_rdata;
  logic signed [7:0] act_row_mem_data, weight_row_mem_data;
  logic [10:0]       act_row_mem_addr;
  logic [8:0]        weight_row_mem_addr;

  logic [7:0] act_mem [0:8191];
  logic [7:0] wgt_mem [0:2047];
  logic [7:0] exp_act_data, exp_wgt_data;
  int n_checks, n_pass;

  act_weight_fetch_ctrlr dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .cfg_err(cfg_err),
    .OC(OC), .IMG_H(IMG_H), .IMG_W(IMG_W), .K(K),
    .act_sram_en(act_sram_en), .act_sram_addr(act_sram_addr), .act_sram_rdata(act_sram_rdata),
    .weight_sram_en(weight_sram_en), .weight_sram_addr(weight_sram_addr),
    .weight_sram_rdata(weight_sram_rdata),
    .act_row_mem_data(act_row_mem_data), .act_row_mem_addr(act_row_mem_addr),
    .weight_row_mem_data(weight_row_mem_data), .weight_row_mem_addr(weight_row_mem_addr)
  );

  always #5 clk = ~clk;

  // SRAM models: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    act_sram_rdata    <= act_sram_en ? act_mem[act_sram_addr] : 8'($urandom);
    weight_sram_rdata <= weight_sram_en ? wgt_mem[weight_sram_addr] : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".cfg_err"}, cfg_err, 0);
    chk({tag, ".act_en"}, act_sram_en, 0);
    chk({tag, ".wgt_en"}, weight_sram_en, 0);
    chk({tag, ".act_sa"}, act_sram_addr, 0);
    chk({tag, ".wgt_sa"}, weight_sram_addr, 0);
    chk({tag, ".act_d"}, {24'd0, act_row_mem_data}, 0);
    chk({tag, ".wgt_d"}, {24'd0, weight_row_mem_data}, 0);
    chk({tag, ".act_a"}, act_row_mem_addr, 0);
    chk({tag, ".wgt_a"}, weight_row_mem_addr, 0);
  endtask

  // One run: start is high in cycle 0; cycle c is observed 1 time unit after edge c.
  task automatic run_cfg(input int oc, input int h, input int w, input int k,
                         input bit noisy, input int rst_at);
    int an, wn, np, len, fe, dc, last_c, r, p, kk, ea, ew;
    bit legal;
    an    = (h + k - 1) * (w + k - 1);
    wn    = k * k * oc;
    legal = (k == 1 || k == 3 || k == 5) && oc >= 1 && h >= 1 && w >= 1 && an <= 2047 && wn <= 511;
    np    = (k == 3) ? 1 : 3;
    len   = (an > wn) ? an : wn;
    fe    = 2 + np * len;
    dc    = fe + 4;
    OC = 6'(oc); IMG_H = 6'(h); IMG_W = 6'(w); K = 3'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    last_c = legal ? dc + 2 : 6;
    for (int c = 1; c <= last_c; c++) begin
      if (c == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_all_zero($sformatf("midrst@%0d", c));
        exp_act_data = 8'd0;
        exp_wgt_data = 8'd0;
        return;
      end
      if (legal) begin
        r = c - 2; p = (r >= 0) ? r / len : 0; kk = (r >= 0) ? r % len : 0;
        chk($sformatf("act_en@%0d", c), act_sram_en, (c >= 2 && c < fe && kk < an));
        chk($sformatf("wgt_en@%0d", c), weight_sram_en, (c >= 2 && c < fe && kk < wn));
        if (c >= 2 && c < fe && kk < an) chk($sformatf("act_sa@%0d", c), act_sram_addr, p * an + kk);
        if (c >= 2 && c < fe && kk < wn) chk($sformatf("wgt_sa@%0d", c), weight_sram_addr, p * wn + kk);
        r = c - 4; p = (r >= 0) ? r / len : 0; kk = (r >= 0) ? r % len : 0;
        if (c < 4) begin
          ea = 0; ew = 0;
        end else if (c - 2 < fe) begin
          if (kk < an) begin ea = kk; exp_act_data = act_mem[p * an + kk]; end
          else ea = an;
          if (kk < wn) begin ew = kk; exp_wgt_data = wgt_mem[p * wn + kk]; end
          else ew = wn;
        end else begin
          ea = an; ew = wn;
        end
        chk($sformatf("act_a@%0d", c), act_row_mem_addr, ea);
        chk($sformatf("wgt_a@%0d", c), weight_row_mem_addr, ew);
        chk($sformatf("act_d@%0d", c), {24'd0, act_row_mem_data}, {24'd0, exp_act_data});
        chk($sformatf("wgt_d@%0d", c), {24'd0, weight_row_mem_data}, {24'd0, exp_wgt_data});
        chk($sformatf("done@%0d", c), done, (c == dc));
        chk($sformatf("cfg_err@%0d", c), cfg_err, 0);
      end else begin
        chk($sformatf("bad.act_en@%0d", c), act_sram_en, 0);
        chk($sformatf("bad.wgt_en@%0d", c), weight_sram_en, 0);
        chk($sformatf("bad.done@%0d", c), done, 0);
        chk($sformatf("bad.cfg_err@%0d", c), cfg_err, (c == 2));
      end
      if (noisy && legal && c < dc - 2) begin
        start = ($urandom_range(0, 2) == 0);
        OC = 6'($urandom); IMG_H = 6'($urandom); IMG_W = 6'($urandom); K = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int ks [5];
    int k, h, w, oc;
    ks = '{1, 3, 5, 2, 3};
    n_checks = 0; n_pass = 0;
    reset = 1'b1; start = 1'b0;
    OC = 6'd0; IMG_H = 6'd0; IMG_W = 6'd0; K = 3'd0;
    exp_act_data = 8'd0; exp_wgt_data = 8'd0;
    for (int i = 0; i < 8192; i++) act_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) wgt_mem[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    run_cfg(2, 2, 2, 3, 1'b0, 0);   // baseline single pass, from IDLE
    run_cfg(2, 2, 2, 3, 1'b0, 0);   // restart from HOLD
    run_cfg(4, 4, 4, 1, 1'b0, 0);   // three passes, no bubble
    run_cfg(2, 2, 2, 2, 1'b0, 0);   // bad K
    run_cfg(1, 63, 63, 3, 1'b0, 0); // activation count too large
    run_cfg(0, 2, 2, 3, 1'b0, 0);   // zero channels
    run_cfg(9, 1, 1, 5, 1'b0, 0);   // weight count 225, legal
    run_cfg(3, 5, 5, 3, 1'b1, 0);   // start and config noise during run
    run_cfg(4, 6, 6, 1, 1'b0, 20);  // reset mid-fetch
    run_cfg(4, 6, 6, 1, 1'b0, 0);   // full run after reset

    for (int i = 0; i < 12; i++) begin
      k  = ks[$urandom_range(0, 4)];
      h  = (i % 5 == 4) ? $urandom_range(40, 63) : $urandom_range(1, 12);
      w  = $urandom_range(1, 12);
      oc = $urandom_range(1, 16);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("gap.done", done, 0);
        chk("gap.act_en", act_sram_en, 0);
      end
      run_cfg(oc, h, w, k, (i % 3 == 0), (i % 4 == 1) ? $urandom_range(3, 10) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
